axi_lite_cmd_master: RTL and testbench
======================================

# axi_lite_cmd_master

Command-driven AXI4-Lite master that feeds the AXI-Lite slave register block, replacing the fixed-pattern example master in register-access benches and in the design. Accepts one register read or write per command over a valid/ready port and executes it as a single AXI4-Lite transaction. Returns read data and response over a second valid/ready port. Keeps a sticky timeout flag and a saturating error counter.

## Interface
- C_BASE_ADDR, 32'h40000000, added to every command offset to form AWADDR/ARADDR
- C_AXI_ADDR_WIDTH, 32, AXI address width
- C_AXI_DATA_WIDTH, 32, AXI data width (32 or 64)
- C_OFS_WIDTH, 16, command offset width (≤ C_AXI_ADDR_WIDTH)
- C_TIMEOUT_CYCLES, 1024, cycles without a handshake before the timeout flag sets (≥ 2)
- i_sys_clk  in  1  single clock; also drives the AXI side
- i_sys_rst  in  1  asynchronous, active-high reset
- i_cmd_valid / o_cmd_ready  in/out  1  command handshake
- i_cmd_wr  in  1  1 = write, 0 = read
- i_cmd_addr  in  C_OFS_WIDTH  byte offset
- i_cmd_wdata  in  C_AXI_DATA_WIDTH  write data
- i_cmd_wstrb  in  C_AXI_DATA_WIDTH/8  write strobes
- o_rsp_valid / i_rsp_ready  out/in  1  response handshake
- o_rsp_wr  out  1  echo of i_cmd_wr
- o_rsp_rdata  out  C_AXI_DATA_WIDTH  read data; 0 for writes
- o_rsp_resp  out  2  BRESP or RRESP
- o_timeout_err  out  1  sticky timeout flag
- o_err_cnt  out  8  saturating count of responses with resp ≠ 2'b00
- M_AXI_AW*, W*, B*, AR*, R*  standard AXI4-Lite master channel ports (ADDR/DATA widths per parameters)

## Operation
- FSM states: IDLE, WR (AW and W outstanding), WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - o_cmd_ready = 1.
  - On i_cmd_valid: latch all command fields.
  - Go to WR (assert AWVALID and WVALID) or RD_ADDR (assert ARVALID).
- Address: AWADDR/ARADDR = C_BASE_ADDR + zero-extended offset, modulo 2^C_AXI_ADDR_WIDTH (wraps; no error). AWPROT = 3'b000, ARPROT = 3'b001.
- WR:
  - AWVALID and WVALID each drop the cycle after their own ready handshake.
  - AW and W may complete in either order or together.
  - When both have completed: BREADY = 1, go to WR_RESP.
- WR_RESP: on BVALID&BREADY, latch BRESP, drop BREADY, go to RSP.
- RD_ADDR: on ARVALID&ARREADY, drop ARVALID, set RREADY = 1, go to RD_DATA.
- RD_DATA: on RVALID&RREADY, latch RDATA and RRESP, drop RREADY, go to RSP.
- RSP:
  - o_rsp_valid = 1; response fields held stable until i_rsp_ready.
  - On the handshake, go to IDLE.
  - o_err_cnt increments (saturates at 255) when resp ≠ 2'b00.
- Timeout:
  - The counter clears on every state change.
  - In WR, WR_RESP, RD_ADDR and RD_DATA it increments each cycle.
  - Reaching C_TIMEOUT_CYCLES sets o_timeout_err (sticky until reset).
  - The transaction is not abandoned; valids stay asserted, so the AXI protocol is never violated.
- Only one transaction is outstanding at a time. Commands are not accepted during RSP.

## Timing
- All outputs are registered.
- Reset values: every VALID/READY output 0, all address/data/strobe/response outputs 0, o_cmd_ready 1, o_timeout_err 0, o_err_cnt 0, state IDLE.
- Command accepted at edge N: AWVALID/WVALID (or ARVALID) high from N+1.
- Zero-wait slave:
  - Write (AWREADY and WREADY at N+1, BVALID at N+2): o_rsp_valid from N+4.
  - Read (ARREADY at N+1, RVALID at N+2): o_rsp_valid from N+4.
- Back-to-back rate: next command accepted the cycle after the rsp handshake.
- AXI valids never drop before their handshake. WDATA/AWADDR stay stable while valid.
- Reset asserted mid-transaction: immediately returns to IDLE with reset values. The slave must be reset together with this block.

## Structure
- Package axi_lite_cmd_pkg:
  - state enum (IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP)
  - response constants OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11
  - PROT_DATA = 3'b000, PROT_RD = 3'b001
- No sub-module. FSM, timeout counter and error counter sit in one module.
- The bench binds this block to the existing axi interface and slave register block (C_S_AXI_ADDR_WIDTH = 4).

## Test plan
- Write 0x4 / data 0x12345678 / wstrb 0xF, then read 0x4 → rsp_wr=1 resp=00, then rsp_wr=0 rdata=0x12345678 resp=00; AWADDR observed 0x40000004.
- Write 0x8 / 0xFFFFFFFF / wstrb 0x3 after reg2=0 → read 0x8 returns 0x0000FFFF.
- Slave holding AWREADY 3 cycles longer than WREADY → WVALID drops first, AWVALID held with stable address; exactly one write occurs.
- i_rsp_ready held low 10 cycles → o_rsp_valid and fields stable, o_cmd_ready = 0, second command not accepted until the response handshake.
- Stubbed slave never asserts ARREADY, C_TIMEOUT_CYCLES = 8 → o_timeout_err = 1 eight cycles into RD_ADDR with ARVALID still high; forced RRESP = 2'b10 → o_err_cnt = 1.
- Reset pulse while in WR_RESP → all AXI valids/readies 0 and o_cmd_ready = 1 the same cycle; following write/read pair completes normally.

Source files
------------

// File: rtl/axi_lite_cmd_pkg.sv
// rtl/axi_lite_cmd_pkg.sv - shared types and constants for the command-driven AXI4-Lite master
package axi_lite_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] PROT_DATA = 3'b000;
  localparam logic [2:0] PROT_RD   = 3'b001;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// rtl/axi_lite_cmd_master_if.sv - AXI4-Lite channel bundle with master/slave modports
interface axi_lite_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - executes one register command per AXI4-Lite transaction, with timeout flag and error count
module axi_lite_cmd_master
  import axi_lite_cmd_pkg::*;
#(
  parameter int                          C_AXI_ADDR_WIDTH = 32,
  parameter int                          C_AXI_DATA_WIDTH = 32,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR      = 'h4000_0000,
  parameter int                          C_OFS_WIDTH      = 16,
  parameter int                          C_TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_sys_clk,
  input  logic                          i_sys_rst,

  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_cmd_wr,
  input  logic [C_OFS_WIDTH-1:0]        i_cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,

  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic                          o_rsp_wr,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                    o_rsp_resp,

  output logic                          o_timeout_err,
  output logic [7:0]                    o_err_cnt,

  axi_lite_cmd_master_if.master         m_axi
);

  localparam int AW   = C_AXI_ADDR_WIDTH;
  localparam int DW   = C_AXI_DATA_WIDTH;
  localparam int SW   = C_AXI_DATA_WIDTH / 8;
  localparam int TW   = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(C_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(C_TIMEOUT_CYCLES);

  state_e          state_q, state_d;

  logic            cmd_ready_q, cmd_ready_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_wr_q, rsp_wr_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;

  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic            cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
  logic            wr_done, busy;
  logic [AW-1:0]   cmd_addr_full;

  assign cmd_hs  = i_cmd_valid && cmd_ready_q && (state_q == IDLE);
  assign aw_hs   = awvalid_q && m_axi.awready;
  assign w_hs    = wvalid_q  && m_axi.wready;
  assign b_hs    = bready_q  && m_axi.bvalid;
  assign ar_hs   = arvalid_q && m_axi.arready;
  assign r_hs    = rready_q  && m_axi.rvalid;
  assign rsp_hs  = rsp_valid_q && i_rsp_ready;

  // A channel counts as done once its valid has dropped or is handshaking now
  assign wr_done = !(awvalid_q && !m_axi.awready) && !(wvalid_q && !m_axi.wready);

  assign busy    = (state_q == WR) || (state_q == WR_RESP) ||
                   (state_q == RD_ADDR) || (state_q == RD_DATA);

  // Address arithmetic wraps at the bus width by construction
  assign cmd_addr_full = C_BASE_ADDR + AW'(i_cmd_addr);

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_hs)  state_d = i_cmd_wr ? WR : RD_ADDR;
      WR:      if (wr_done) state_d = WR_RESP;
      WR_RESP: if (b_hs)    state_d = RSP;
      RD_ADDR: if (ar_hs)   state_d = RD_DATA;
      RD_DATA: if (r_hs)    state_d = RSP;
      RSP:     if (rsp_hs)  state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = timeout_q;
    err_cnt_d   = err_cnt_q;

    // Response fields are captured on the bus handshake and presented one cycle into RSP
    rsp_valid_d = (state_q == RSP) && !rsp_hs;

    if (cmd_hs) begin
      rsp_wr_d = i_cmd_wr;
      if (i_cmd_wr) begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        awaddr_d  = cmd_addr_full;
        wdata_d   = i_cmd_wdata;
        wstrb_d   = i_cmd_wstrb;
      end else begin
        arvalid_d = 1'b1;
        araddr_d  = cmd_addr_full;
      end
    end

    if (aw_hs) awvalid_d = 1'b0;
    if (w_hs)  wvalid_d  = 1'b0;
    if ((state_q == WR) && wr_done) bready_d = 1'b1;

    if (b_hs) begin
      bready_d    = 1'b0;
      rsp_resp_d  = m_axi.bresp;
      rsp_rdata_d = '0;
    end

    if (ar_hs) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b1;
    end

    if (r_hs) begin
      rready_d    = 1'b0;
      rsp_rdata_d = m_axi.rdata;
      rsp_resp_d  = m_axi.rresp;
    end

    if (rsp_hs && (rsp_resp_q != OKAY)) err_cnt_d = sat_inc8(err_cnt_q);

    // Timeout only flags a stall; the transaction keeps waiting on the slave
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (busy) begin
      if (tmo_cnt_q != TMO_MAX)  tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_q == TMO_LAST) timeout_d = 1'b1;
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_wr      = rsp_wr_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_resp    = rsp_resp_q;
  assign o_timeout_err = timeout_q;
  assign o_err_cnt     = err_cnt_q;

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = PROT_DATA;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = PROT_RD;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - directed bench for axi_lite_cmd_master against a 4-register AXI-Lite slave model
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_wr;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout_err;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_lite_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi_lite_cmd_master #(
    .C_AXI_ADDR_WIDTH (32),
    .C_AXI_DATA_WIDTH (32),
    .C_BASE_ADDR      (32'h4000_0000),
    .C_OFS_WIDTH      (16),
    .C_TIMEOUT_CYCLES (8)
  ) dut (
    .i_sys_clk     (clk),
    .i_sys_rst     (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_wr      (cmd_wr),
    .i_cmd_addr    (cmd_addr),
    .i_cmd_wdata   (cmd_wdata),
    .i_cmd_wstrb   (cmd_wstrb),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_wr      (rsp_wr),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_resp    (rsp_resp),
    .o_timeout_err (timeout_err),
    .o_err_cnt     (err_cnt),
    .m_axi         (axi)
  );

  // Slave register block model, 4-bit address space
  int          aw_delay = 0;
  int          aw_wait;
  logic        ar_en = 1'b1;
  logic [1:0]  force_rresp = 2'b00;
  logic [31:0] regs [4];
  logic        aw_got, w_got, bvalid_r, rvalid_r;
  logic [31:0] aw_l, w_l, rdata_r;
  logic [3:0]  s_l;
  logic [1:0]  rresp_r;
  int          wr_count;

  assign axi.awready = axi.awvalid && (aw_wait >= aw_delay);
  assign axi.wready  = axi.wvalid;
  assign axi.arready = axi.arvalid && ar_en;
  assign axi.bvalid  = bvalid_r;
  assign axi.bresp   = 2'b00;
  assign axi.rvalid  = rvalid_r;
  assign axi.rdata   = rdata_r;
  assign axi.rresp   = rresp_r;

  always @(posedge clk or posedge rst) begin : slv
    logic        ha, hw;
    logic [31:0] a, d;
    logic [3:0]  s;
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      aw_wait <= 0; aw_got <= 0; w_got <= 0; bvalid_r <= 0; rvalid_r <= 0;
      aw_l <= '0; w_l <= '0; s_l <= '0; rdata_r <= '0; rresp_r <= '0; wr_count <= 0;
    end else begin
      aw_wait <= (axi.awvalid && !axi.awready) ? aw_wait + 1 : 0;
      ha = aw_got; a = aw_l; hw = w_got; d = w_l; s = s_l;
      if (axi.awvalid && axi.awready) begin ha = 1'b1; a = axi.awaddr; end
      if (axi.wvalid && axi.wready) begin hw = 1'b1; d = axi.wdata; s = axi.wstrb; end
      if (bvalid_r && axi.bready) bvalid_r <= 1'b0;
      if (ha && hw && !bvalid_r) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) regs[a[3:2]][i*8 +: 8] <= d[i*8 +: 8];
        wr_count <= wr_count + 1;
        bvalid_r <= 1'b1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        aw_got <= ha; aw_l <= a; w_got <= hw; w_l <= d; s_l <= s;
      end
      if (rvalid_r && axi.rready) rvalid_r <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        rvalid_r <= 1'b1;
        rdata_r  <= regs[axi.araddr[3:2]];
        rresp_r  <= force_rresp;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge
  task automatic send_cmd(input logic wr, input logic [15:0] ofs,
                          input logic [31:0] wd, input logic [3:0] ws);
    int n;
    n = 0;
    cmd_wr = wr; cmd_addr = ofs; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic wr, output logic [31:0] rd,
                         output logic [1:0] rs, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin tick(); lat++; end
    chk("rsp_valid_wait", rsp_valid, 1);
    wr = rsp_wr; rd = rsp_rdata; rs = rsp_resp;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic        w;
    logic [31:0] rd, held;
    logic [1:0]  rs;
    int          lat, wc, n;
    logic        stable;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid",   axi.awvalid, 0);
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}, 6'b0);
    chk("idle_awaddr", axi.awaddr, 32'h0);
    chk("idle_timeout", timeout_err, 0);
    chk("idle_err_cnt", err_cnt, 8'd0);

    // Basic write then read of offset 0x4
    send_cmd(1'b1, 16'h0004, 32'h1234_5678, 4'hF);
    chk("wr_awvalid", axi.awvalid, 1);
    chk("wr_wvalid", axi.wvalid, 1);
    chk("wr_awaddr", axi.awaddr, 32'h4000_0004);
    chk("wr_awprot", axi.awprot, 3'b000);
    chk("wr_wdata", axi.wdata, 32'h1234_5678);
    chk("wr_cmd_ready_busy", cmd_ready, 0);
    get_rsp(w, rd, rs, lat);
    chk("wr_lat", lat, 3);
    chk("wr_rsp_wr", w, 1);
    chk("wr_rsp_resp", rs, 2'b00);
    chk("wr_rsp_rdata", rd, 32'h0);
    chk("wr_cmd_ready_back", cmd_ready, 1);

    send_cmd(1'b0, 16'h0004, 32'h0, 4'h0);
    chk("rd_arvalid", axi.arvalid, 1);
    chk("rd_araddr", axi.araddr, 32'h4000_0004);
    chk("rd_arprot", axi.arprot, 3'b001);
    get_rsp(w, rd, rs, lat);
    chk("rd_lat", lat, 3);
    chk("rd_rsp_wr", w, 0);
    chk("rd_rsp_rdata", rd, 32'h1234_5678);
    chk("rd_rsp_resp", rs, 2'b00);

    // Partial strobe write
    send_cmd(1'b1, 16'h0008, 32'h0, 4'hF);
    get_rsp(w, rd, rs, lat);
    send_cmd(1'b1, 16'h0008, 32'hFFFF_FFFF, 4'h3);
    get_rsp(w, rd, rs, lat);
    send_cmd(1'b0, 16'h0008, 32'h0, 4'h0);
    get_rsp(w, rd, rs, lat);
    chk("strb_rdata", rd, 32'h0000_FFFF);

    // AWREADY three cycles later than WREADY
    aw_delay = 3;
    wc = wr_count;
    send_cmd(1'b1, 16'h000C, 32'hA5A5_5A5A, 4'hF);
    tick();
    chk("awlate_wvalid_dropped", axi.wvalid, 0);
    chk("awlate_awvalid_n1", axi.awvalid, 1);
    tick();
    chk("awlate_awvalid_n2", axi.awvalid, 1);
    chk("awlate_awaddr_n2", axi.awaddr, 32'h4000_000C);
    tick();
    chk("awlate_awvalid_n3", axi.awvalid, 1);
    chk("awlate_awaddr_n3", axi.awaddr, 32'h4000_000C);
    get_rsp(w, rd, rs, lat);
    chk("awlate_lat", lat, 3);
    chk("awlate_one_write", wr_count - wc, 1);
    aw_delay = 0;
    send_cmd(1'b0, 16'h000C, 32'h0, 4'h0);
    get_rsp(w, rd, rs, lat);
    chk("awlate_rdata", rd, 32'hA5A5_5A5A);

    // Response back-pressure
    send_cmd(1'b0, 16'h0004, 32'h0, 4'h0);
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    chk("hold_rsp_wait", rsp_valid, 1);
    held = rsp_rdata;
    cmd_wr = 1'b1; cmd_addr = 16'h0000; cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(rsp_valid && rsp_rdata == held && !rsp_wr && rsp_resp == 2'b00 &&
            !cmd_ready && !axi.awvalid && !axi.arvalid)) stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    chk("hold_rdata", held, 32'h1234_5678);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hold_rsp_valid_after", rsp_valid, 0);
    chk("hold_cmd_ready_after", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("hold_second_accepted", axi.awvalid, 1);
    get_rsp(w, rd, rs, lat);
    chk("hold_second_rsp_wr", w, 1);
    chk("err_cnt_before_tmo", err_cnt, 8'd0);

    // Read against a slave that withholds ARREADY
    ar_en = 1'b0;
    force_rresp = 2'b10;
    send_cmd(1'b0, 16'h0000, 32'h0, 4'h0);
    repeat (7) tick();
    chk("tmo_not_yet", timeout_err, 0);
    tick();
    chk("tmo_set", timeout_err, 1);
    chk("tmo_arvalid_held", axi.arvalid, 1);
    ar_en = 1'b1;
    get_rsp(w, rd, rs, lat);
    force_rresp = 2'b00;
    chk("tmo_rresp", rs, 2'b10);
    chk("tmo_rdata", rd, 32'hCAFE_F00D);
    chk("err_cnt_one", err_cnt, 8'd1);
    chk("tmo_sticky", timeout_err, 1);

    // Reset while waiting for the write response
    send_cmd(1'b1, 16'h0000, 32'h1111_1111, 4'hF);
    tick();
    chk("rstmid_in_wr_resp", axi.bready, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}, 6'b0);
    chk("rstmid_cmd_ready", cmd_ready, 1);
    chk("rstmid_timeout", timeout_err, 0);
    chk("rstmid_err_cnt", err_cnt, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    send_cmd(1'b1, 16'h0000, 32'h0BAD_F00D, 4'hF);
    get_rsp(w, rd, rs, lat);
    chk("post_rst_wr_resp", rs, 2'b00);
    send_cmd(1'b0, 16'h0000, 32'h0, 4'h0);
    get_rsp(w, rd, rs, lat);
    chk("post_rst_rdata", rd, 32'h0BAD_F00D);
    chk("post_rst_lat", lat, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
